// File: rtl/tm_pkg.sv
// Shared definitions for the transactional-memory tracker: default widths,
// default ALU latency and the controller state encoding.
package tm_pkg;

  localparam int TM_W       = 8;
  localparam int TM_ALU_LAT = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_TX  = 2'd1,
    UPDATE = 2'd2
  } tm_state_t;

endpackage

// File: rtl/tm_sat_cnt.sv
// W-bit saturating up-counter with synchronous clear (clear wins over increment).
module tm_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count up to all-ones and stick there until cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (inc && (cnt != '1)) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/tm_tx_tracker.sv
// Transaction tracker feeding tm_alu: counts retired instructions inside an open
// transaction and writes back AvgTxLen/InstExed after the ALU latency on commit.
// Optional abort statistics (abort_cnt, last_abort_len) when TM_ABORT_STATS_EN is defined.
//
//   state  | meaning
//   IDLE   | no open transaction; ctl holds the last length
//   IN_TX  | transaction open; inst_valid counts into ctl
//   UPDATE | commit seen; operands held for ALU_LAT cycles, then write-back
module tm_tx_tracker
  import tm_pkg::*;
#(
  parameter int W       = TM_W,
  parameter int ALU_LAT = TM_ALU_LAT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_begin,
  input  logic         inst_valid,
  input  logic         tx_commit,
  input  logic         tx_abort,
  input  logic [W-1:0] atln,
  input  logic [W-1:0] ien,
  output logic [W-1:0] atl,
  output logic [W-1:0] ie,
  output logic [W-1:0] ctl,
  output logic         busy,
  output logic         upd_done
`ifdef TM_ABORT_STATS_EN
  ,
  output logic [W-1:0] abort_cnt,
  output logic [W-1:0] last_abort_len
`endif
);

  localparam logic [W-1:0] LAT_LAST = W'(ALU_LAT - 1);
  localparam logic [W-1:0] SAT_MAX  = {W{1'b1}};

  tm_state_t    state, state_nxt;
  logic         begin_acc, abort_acc, upd_last;
  logic         ctl_inc;
  logic [W-1:0] tmr;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and one-cycle transition strobes; abort has priority over commit
  always_comb begin
    state_nxt = state;
    begin_acc = 1'b0;
    abort_acc = 1'b0;
    upd_last  = 1'b0;
    case (state)
      IDLE: begin
        if (tx_begin) begin
          begin_acc = 1'b1;
          state_nxt = IN_TX;
        end
      end
      IN_TX: begin
        if (tx_abort) begin
          abort_acc = 1'b1;
          state_nxt = IDLE;
        end else if (tx_commit) begin
          state_nxt = UPDATE;
        end
      end
      UPDATE: begin
        if (tmr == LAT_LAST) begin
          upd_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ctl_inc = (state == IN_TX) && inst_valid;
  assign busy    = (state == UPDATE);

  tm_sat_cnt #(.W(W)) u_ctl (
    .clk   (clk),
    .reset (reset),
    .clr   (begin_acc),
    .inc   (ctl_inc),
    .cnt   (ctl)
  );

  // latency timer: parked at zero outside UPDATE, counts cycles spent in UPDATE
  tm_sat_cnt #(.W(W)) u_tmr (
    .clk   (clk),
    .reset (reset),
    .clr   (state != UPDATE),
    .inc   (state == UPDATE),
    .cnt   (tmr)
  );

  // write-back of the averages; a saturated ie is never replaced
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      atl      <= '0;
      ie       <= '0;
      upd_done <= 1'b0;
    end else begin
      upd_done <= upd_last;
      if (upd_last) begin
        atl <= atln;
        if (ie != SAT_MAX) ie <= ien;
      end
    end
  end

`ifdef TM_ABORT_STATS_EN
  tm_sat_cnt #(.W(W)) u_abort (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .inc   (abort_acc),
    .cnt   (abort_cnt)
  );

  // capture length at abort, including an instruction retired in the abort cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          last_abort_len <= '0;
    else if (abort_acc && ctl_inc && (ctl != SAT_MAX)) last_abort_len <= ctl + 1'b1;
    else if (abort_acc)                  last_abort_len <= ctl;
  end
`else
  logic abort_unused;
  assign abort_unused = abort_acc;
`endif

endmodule

// File: tb/tb_tm_tx_tracker.sv
// Self-checking bench for tm_tx_tracker with a behavioural tm_alu stand-in downstream.
module tb_tm_tx_tracker;

  localparam int W       = 8;
  localparam int ALU_LAT = 1;
  localparam int MAXV    = 255;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         tx_begin = 1'b0, inst_valid = 1'b0, tx_commit = 1'b0, tx_abort = 1'b0;
  logic [W-1:0] atln, ien, atl, ie, ctl;
  logic         busy, upd_done;
`ifdef TM_ABORT_STATS_EN
  logic [W-1:0] abort_cnt, last_abort_len;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference state
  int m_atl = 0, m_ie = 0, m_abort = 0, m_last = 0;

  tm_tx_tracker #(.W(W), .ALU_LAT(ALU_LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_begin   (tx_begin),
    .inst_valid (inst_valid),
    .tx_commit  (tx_commit),
    .tx_abort   (tx_abort),
    .atln       (atln),
    .ien        (ien),
    .atl        (atl),
    .ie         (ie),
    .ctl        (ctl),
    .busy       (busy),
    .upd_done   (upd_done)
`ifdef TM_ABORT_STATS_EN
    ,
    .abort_cnt      (abort_cnt),
    .last_abort_len (last_abort_len)
`endif
  );

  // downstream ALU: running average over ie+1 transactions; ien wraps so the hold at 255 matters
  assign atln = W'((32'(atl) * 32'(ie) + 32'(ctl)) / (32'(ie) + 32'd1));
  assign ien  = ie + 8'd1;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    tx_begin = 0; inst_valid = 0; tx_commit = 0; tx_abort = 0;
  endtask

  task automatic model_reset();
    m_atl = 0; m_ie = 0; m_abort = 0; m_last = 0;
  endtask

  // open, run n instructions (random gaps and stray nested begins), close with kind:
  // 0 commit, 1 abort, 2 commit+abort. hold_begin keeps tx_begin high through UPDATE.
  task automatic run_tx(input int n, input int kind, input bit hold_begin);
    int  exp_ctl, exp_atl, exp_ie, sent;
    bit  fold;
    fold = (n > 0) && ($urandom_range(0, 1) == 1);
    tx_begin = 1; tick(); tx_begin = 0;
    n_vec++;
    if (ctl !== 0 || busy !== 0) begin
      n_err++; $display("FAIL begin_clear: ctl=%0d busy=%0d, want ctl=0 busy=0", ctl, busy);
    end
    sent = 0;
    while (sent < n - (fold ? 1 : 0)) begin
      inst_valid = ($urandom_range(0, 3) != 0);
      tx_begin   = ($urandom_range(0, 7) == 0);
      if (inst_valid) sent++;
      tick();
    end
    inst_valid = fold; tx_begin = 0;
    tx_commit = (kind != 1); tx_abort = (kind != 0);
    exp_ctl = (n > MAXV) ? MAXV : n;
    tick();
    clear_inputs();
    n_vec++;
    if (ctl !== W'(exp_ctl)) begin
      n_err++; $display("FAIL close_ctl: ctl=%0d, want %0d", ctl, exp_ctl);
    end
    if (kind != 0) begin
      m_abort = (m_abort < MAXV) ? m_abort + 1 : MAXV;
      m_last  = exp_ctl;
      n_vec++;
      if (busy !== 0 || upd_done !== 0 || atl !== W'(m_atl) || ie !== W'(m_ie)) begin
        n_err++; $display("FAIL abort_hold: busy=%0d upd=%0d atl=%0d ie=%0d, want 0 0 %0d %0d",
                          busy, upd_done, atl, ie, m_atl, m_ie);
      end
`ifdef TM_ABORT_STATS_EN
      n_vec++;
      if (abort_cnt !== W'(m_abort) || last_abort_len !== W'(m_last)) begin
        n_err++; $display("FAIL abort_stats: cnt=%0d len=%0d, want %0d %0d",
                          abort_cnt, last_abort_len, m_abort, m_last);
      end
`endif
      inst_valid = 1; tx_commit = 1; tx_abort = 1;
      tick();
      clear_inputs();
      n_vec++;
      if (upd_done !== 0 || ctl !== W'(exp_ctl) || busy !== 0) begin
        n_err++; $display("FAIL idle_ignore: upd=%0d ctl=%0d busy=%0d, want 0 %0d 0",
                          upd_done, ctl, busy, exp_ctl);
      end
    end else begin
      exp_atl = (m_atl * m_ie + exp_ctl) / (m_ie + 1);
      exp_ie  = (m_ie == MAXV) ? MAXV : m_ie + 1;
      for (int c = 0; c < ALU_LAT; c++) begin
        n_vec++;
        if (busy !== 1 || upd_done !== 0 || atl !== W'(m_atl) || ie !== W'(m_ie) || ctl !== W'(exp_ctl)) begin
          n_err++; $display("FAIL update_hold: busy=%0d upd=%0d atl=%0d ie=%0d ctl=%0d, want 1 0 %0d %0d %0d",
                            busy, upd_done, atl, ie, ctl, m_atl, m_ie, exp_ctl);
        end
        if (hold_begin) begin tx_begin = 1; inst_valid = 1; end
        tick();
      end
      m_atl = exp_atl;
      m_ie  = exp_ie;
      n_vec++;
      if (upd_done !== 1 || busy !== 0 || atl !== W'(m_atl) || ie !== W'(m_ie) || ctl !== W'(exp_ctl)) begin
        n_err++; $display("FAIL writeback: upd=%0d busy=%0d atl=%0d ie=%0d ctl=%0d, want 1 0 %0d %0d %0d",
                          upd_done, busy, atl, ie, ctl, m_atl, m_ie, exp_ctl);
      end
      tick();
      n_vec++;
      if (upd_done !== 0) begin
        n_err++; $display("FAIL upd_pulse: upd=%0d, want 0", upd_done);
      end
      if (hold_begin) begin
        n_vec++;
        if (ctl !== 0 || busy !== 0) begin
          n_err++; $display("FAIL held_begin: ctl=%0d busy=%0d, want 0 0", ctl, busy);
        end
      end
      clear_inputs();
    end
  endtask

  task automatic test_reset();
    reset = 0;
    #1;
    n_vec++;
    if (atl !== 0 || ie !== 0 || ctl !== 0 || busy !== 0 || upd_done !== 0) begin
      n_err++; $display("FAIL reset_init: atl=%0d ie=%0d ctl=%0d busy=%0d upd=%0d, want all 0",
                        atl, ie, ctl, busy, upd_done);
    end
    repeat (2) tick();
    reset = 1;
    model_reset();
    tick();
  endtask

  task automatic test_spec_sequence();
    run_tx(4, 0, 0);
    n_vec++;
    if (atl !== 4 || ie !== 1) begin
      n_err++; $display("FAIL first_avg: atl=%0d ie=%0d, want 4 1", atl, ie);
    end
    run_tx(8, 0, 0);
    n_vec++;
    if (atl !== 6 || ie !== 2) begin
      n_err++; $display("FAIL second_avg: atl=%0d ie=%0d, want 6 2", atl, ie);
    end
    run_tx(5, 1, 0);
    n_vec++;
    if (atl !== 6 || ie !== 2 || ctl !== 5) begin
      n_err++; $display("FAIL abort_keep: atl=%0d ie=%0d ctl=%0d, want 6 2 5", atl, ie, ctl);
    end
  endtask

  task automatic test_saturation();
    run_tx(300, 0, 0);
    run_tx(270, 2, 0);
    n_vec++;
    if (busy !== 0 || ctl !== 8'd255) begin
      n_err++; $display("FAIL both_close: busy=%0d ctl=%0d, want 0 255", busy, ctl);
    end
  endtask

  task automatic test_random();
    int guard = 0;
    while (m_ie < MAXV && guard < 2000) begin
      int n, kind;
      n    = ($urandom_range(0, 39) == 0) ? $urandom_range(250, 290) : $urandom_range(0, 20);
      kind = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      run_tx(n, kind, 0);
      guard++;
    end
  endtask

  task automatic test_back_to_back();
    run_tx($urandom_range(1, 12), 0, 1);
    tx_abort = 1; tick(); clear_inputs();
    m_abort = (m_abort < MAXV) ? m_abort + 1 : MAXV;
    m_last  = 0;
    n_vec++;
    if (busy !== 0 || ctl !== 0 || ie !== W'(m_ie) || atl !== W'(m_atl)) begin
      n_err++; $display("FAIL b2b_abort: busy=%0d ctl=%0d ie=%0d atl=%0d, want 0 0 %0d %0d",
                        busy, ctl, ie, atl, m_ie, m_atl);
    end
`ifdef TM_ABORT_STATS_EN
    n_vec++;
    if (abort_cnt !== W'(m_abort) || last_abort_len !== 0) begin
      n_err++; $display("FAIL b2b_stats: cnt=%0d len=%0d, want %0d 0", abort_cnt, last_abort_len, m_abort);
    end
`endif
    n_vec++;
    if (ie !== 8'd255) begin
      n_err++; $display("FAIL ie_sat: ie=%0d, want 255", ie);
    end
  endtask

  task automatic test_reset_mid();
    tx_begin = 1; tick(); tx_begin = 0;
    inst_valid = 1; repeat (3) tick();
    tx_commit = 1; tick(); clear_inputs();
    n_vec++;
    if (busy !== 1) begin
      n_err++; $display("FAIL pre_reset_busy: busy=%0d, want 1", busy);
    end
    #2;
    reset = 0;
    #1;
    model_reset();
    n_vec++;
    if (atl !== 0 || ie !== 0 || ctl !== 0 || busy !== 0 || upd_done !== 0) begin
      n_err++; $display("FAIL reset_async: atl=%0d ie=%0d ctl=%0d busy=%0d upd=%0d, want all 0",
                        atl, ie, ctl, busy, upd_done);
    end
    tick();
    reset = 1;
    tick();
    n_vec++;
    if (atl !== 0 || ie !== 0 || busy !== 0 || upd_done !== 0) begin
      n_err++; $display("FAIL reset_abandon: atl=%0d ie=%0d busy=%0d upd=%0d, want all 0",
                        atl, ie, busy, upd_done);
    end
    run_tx(4, 0, 0);
  endtask

  initial begin
    test_reset();
    test_spec_sequence();
    test_saturation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
